// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: i_cache request/response, redirect input and decode-side queue head.
// master = fetch unit, slave = environment (i_cache, redirect source, decode).
interface ifu_fetch_if;
  logic [63:0] inst_addr;
  logic        inst_ena;
  logic        inst_ack;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;

  modport master (
    output inst_addr, inst_ena, inst_ready, id_valid, id_inst, id_pc,
    input  inst_ack, inst_data, inst_valid, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  inst_addr, inst_ena, inst_ready, id_valid, id_inst, id_pc,
    output inst_ack, inst_data, inst_valid, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding i_cache fetch FSM feeding a small {pc, inst} queue.
// YSYX22040228_IFU_FQ2_EN selects a two-entry queue; default is a single pipe register.
//
// state | meaning
// IDLE  | queue has no free slot, waiting for decode to drain
// REQ   | inst_ena asserted with inst_addr = PC, waiting for inst_ack
// WAIT  | request accepted, waiting for inst_valid to enqueue
// DROP  | request accepted but redirected, discard its response
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic          clk,
  input logic          rst,
  ifu_fetch_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    WAIT = 4'b0100,
    DROP = 4'b1000
  } state_t;

  localparam logic [63:0] ALIGN_MASK = ~64'h3;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pc_aligned;
  logic [63:0] pc_inflight;
  logic        redirect;
  logic        ack_hs;
  logic        push;
  logic        pop;
  logic        slot_free;
  logic        free_after_push;
  logic        ena_c;
  logic        ready_c;
  logic        q_valid;
  logic [63:0] head_pc;
  logic [31:0] head_inst;

  assign redirect   = bus.redirect_valid;
  assign pc_aligned = pc & ALIGN_MASK;
  assign ack_hs     = (state == REQ) && bus.inst_ack;
  // A response coinciding with a redirect belongs to the old stream and is never queued.
  assign push       = (state == WAIT) && bus.inst_valid && !redirect;
  assign pop        = q_valid && bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ena_c     = 1'b0;
    ready_c   = 1'b0;
    case (state)
      IDLE: begin
        if (redirect || slot_free) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        ena_c = 1'b1;
        if (bus.inst_ack) begin
          state_nxt = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        ready_c = 1'b1;
        if (redirect) begin
          state_nxt = bus.inst_valid ? REQ : DROP;
        end else if (bus.inst_valid) begin
          state_nxt = free_after_push ? REQ : IDLE;
        end
      end
      DROP: begin
        ready_c = 1'b1;
        // The stale response retires the outstanding request even if a new redirect arrives with it.
        if (bus.inst_valid) begin
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      pc_inflight <= '0;
    end else if (redirect) begin
      pc <= bus.redirect_pc;
    end else if (ack_hs) begin
      pc_inflight <= pc_aligned;
      pc          <= pc_aligned + 64'd4;
    end
  end

`ifdef YSYX22040228_IFU_FQ2_EN
  logic [63:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= pc_inflight;
        q_inst[wr_ptr] <= bus.inst_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign q_valid         = (count != 2'd0);
  assign head_pc         = q_pc[rd_ptr];
  assign head_inst       = q_inst[rd_ptr];
  assign slot_free       = (count < 2'd2);
  assign count_push      = count + 2'd1 - {1'b0, pop};
  assign free_after_push = (count_push < 2'd2);
`else
  logic        q_full;
  logic [63:0] q_pc;
  logic [31:0] q_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_full <= 1'b0;
      q_pc   <= '0;
      q_inst <= '0;
    end else if (redirect) begin
      q_full <= 1'b0;
    end else if (push) begin
      q_full <= 1'b1;
      q_pc   <= pc_inflight;
      q_inst <= bus.inst_data;
    end else if (pop) begin
      q_full <= 1'b0;
    end
  end

  assign q_valid         = q_full;
  assign head_pc         = q_pc;
  assign head_inst       = q_inst;
  // A draining entry frees the only slot in the same cycle.
  assign slot_free       = !q_full || pop;
  assign free_after_push = 1'b0;
`endif

  assign bus.inst_addr  = pc_aligned;
  assign bus.inst_ena   = ena_c;
  assign bus.inst_ready = ready_c;
  assign bus.id_valid   = q_valid;
  assign bus.id_pc      = head_pc;
  assign bus.id_inst    = head_inst;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reactive i_cache/decode model with a {pc, inst} scoreboard.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
`ifdef YSYX22040228_IFU_FQ2_EN
  localparam int DEPTH     = 2;
  localparam int MIN_POPS  = 10;
`else
  localparam int DEPTH     = 1;
  localparam int MIN_POPS  = 6;
`endif

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic clk;
  logic rst;
  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_t         sb [$];
  int          n_checks;
  int          n_errors;
  int          n_ack;
  int          n_pop;
  logic        ack_en;
  logic        rdy_mode;
  int          resp_lat;
  logic        resp_pend;
  int          resp_cnt;
  logic [63:0] resp_pc;
  logic        resp_stale;
  logic        resp_after_rst;
  logic [63:0] exp_addr;
  logic [63:0] last_ack_addr;

  function automatic logic [31:0] data_of(input logic [63:0] p);
    return p[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: called just after an edge, drives this cycle's inputs, then advances.
  task automatic cyc(input logic redir, input logic [63:0] tgt);
    bus.inst_ack       = 1'b0;
    bus.inst_valid     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.id_ready       = rdy_mode;
    if (rst) begin
      sb.delete();
      exp_addr = RESET_PC;
      if (resp_pend) resp_after_rst = 1'b1;
    end
    if (!rst && resp_pend && !resp_after_rst) chk("single_outstanding", bus.inst_ena, 0);
    if (!rst && bus.id_valid === 1'b1) begin
      chk("no_stale_id_valid", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        chk("id_pc", bus.id_pc, sb[0].pc);
        chk("id_inst", bus.id_inst, sb[0].inst);
        if (rdy_mode && !redir) begin
          void'(sb.pop_front());
          n_pop++;
        end
      end
    end
    if (resp_pend) begin
      if (resp_cnt <= 1) begin
        bus.inst_valid = 1'b1;
        bus.inst_data  = data_of(resp_pc);
        resp_pend      = 1'b0;
        if (!rst) chk("inst_ready_on_resp", bus.inst_ready, resp_after_rst ? 0 : 1);
        if (!rst && !resp_stale && !resp_after_rst && !redir)
          sb.push_back('{resp_pc, data_of(resp_pc)});
        resp_stale     = 1'b0;
        resp_after_rst = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    if (!rst && ack_en && bus.inst_ena === 1'b1 && !resp_pend) begin
      bus.inst_ack  = 1'b1;
      chk("inst_addr", bus.inst_addr, exp_addr);
      last_ack_addr = bus.inst_addr;
      resp_pend     = 1'b1;
      resp_cnt      = resp_lat;
      resp_pc       = exp_addr;
      resp_stale    = redir;
      exp_addr      = exp_addr + 64'd4;
      n_ack++;
    end
    if (redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = tgt;
      if (!rst) begin
        sb.delete();
        exp_addr = tgt;
        if (resp_pend) resp_stale = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc(1'b0, '0);
    rst   = 1'b0;
    n_ack = 0;
    n_pop = 0;
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit && bus.inst_ready !== 1'b1; i++) cyc(1'b0, '0);
    chk("wait_inst_ready", bus.inst_ready, 1);
  endtask

  task automatic run_until_ack(input int limit);
    int start;
    start = n_ack;
    for (int i = 0; i < limit && n_ack == start; i++) cyc(1'b0, '0);
    chk("ack_seen", n_ack > start, 1);
  endtask

  task automatic wait_id_valid(input int limit);
    for (int i = 0; i < limit && bus.id_valid !== 1'b1; i++) cyc(1'b0, '0);
    chk("wait_id_valid", bus.id_valid, 1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_ack = 0; n_pop = 0;
    ack_en = 1'b1; rdy_mode = 1'b1; resp_lat = 1;
    resp_pend = 1'b0; resp_cnt = 0; resp_pc = '0; resp_stale = 1'b0; resp_after_rst = 1'b0;
    exp_addr = RESET_PC; last_ack_addr = '0;
    bus.inst_ack = 1'b0; bus.inst_data = '0; bus.inst_valid = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, with a redirect applied during reset that must be ignored.
    cyc(1'b0, '0);
    cyc(1'b1, 64'h0000_0000_0000_1234);
    chk("rst_inst_ena", bus.inst_ena, 0);
    chk("rst_inst_ready", bus.inst_ready, 0);
    chk("rst_inst_addr", bus.inst_addr, RESET_PC);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_inst", bus.id_inst, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    rst = 1'b0;

    // Streaming fetch with an immediately acking cache and a free-running decoder.
    n_pop = 0;
    repeat (24) cyc(1'b0, '0);
    chk("stream_pops", n_pop >= MIN_POPS, 1);

    // Decode stalled: queue fills to its depth and fetching stops.
    do_reset();
    rdy_mode = 1'b0;
    repeat (12) cyc(1'b0, '0);
    chk("stall_acks", n_ack, DEPTH);
    chk("stall_inst_ena", bus.inst_ena, 0);
    chk("stall_id_valid", bus.id_valid, 1);
    chk("stall_id_pc", bus.id_pc, RESET_PC);

    // Redirect in IDLE flushes the full queue; redirect in REQ without ack withdraws the request.
    cyc(1'b1, 64'h0000_0000_8000_2000);
    chk("idle_redir_id_valid", bus.id_valid, 0);
    chk("idle_redir_ena", bus.inst_ena, 1);
    chk("idle_redir_addr", bus.inst_addr, 64'h0000_0000_8000_2000);
    ack_en = 1'b0;
    cyc(1'b1, 64'h0000_0000_8000_3000);
    chk("req_redir_ena", bus.inst_ena, 1);
    chk("req_redir_addr", bus.inst_addr, 64'h0000_0000_8000_3000);
    ack_en   = 1'b1;
    rdy_mode = 1'b1;
    run_until_ack(10);
    chk("req_redir_ack_addr", last_ack_addr, 64'h0000_0000_8000_3000);
    repeat (10) cyc(1'b0, '0);

    // Redirect in WAIT, response three cycles later is dropped.
    do_reset();
    resp_lat = 4;
    wait_ready(10);
    cyc(1'b1, 64'h0000_0000_8000_1000);
    chk("wait_redir_id_valid", bus.id_valid, 0);
    chk("wait_redir_ena", bus.inst_ena, 0);
    run_until_ack(12);
    chk("wait_redir_ack_addr", last_ack_addr, 64'h0000_0000_8000_1000);
    resp_lat = 1;
    repeat (10) cyc(1'b0, '0);

    // Redirect coincident with inst_valid: next cycle requests the target.
    do_reset();
    wait_ready(10);
    cyc(1'b1, 64'h0000_0000_8000_1000);
    chk("valid_redir_ena", bus.inst_ena, 1);
    chk("valid_redir_addr", bus.inst_addr, 64'h0000_0000_8000_1000);
    chk("valid_redir_id_valid", bus.id_valid, 0);
    repeat (8) cyc(1'b0, '0);

    // PC wraps modulo 2^64.
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_until_ack(10);
    chk("wrap_first_addr", last_ack_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    run_until_ack(10);
    chk("wrap_next_addr", last_ack_addr, 64'h0);
    repeat (8) cyc(1'b0, '0);

    // Reset during WAIT: the late response must meet inst_ready=0, fetch restarts at RESET_PC.
    do_reset();
    resp_lat = 3;
    wait_ready(10);
    rst = 1'b1;
    cyc(1'b0, '0);
    rst   = 1'b0;
    n_ack = 0;
    wait_id_valid(20);
    chk("post_rst_first_id_pc", bus.id_pc, RESET_PC);
    chk("post_rst_first_id_inst", bus.id_inst, data_of(RESET_PC));
    repeat (10) cyc(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
